// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types and constants for the gated frequency counter.
//   state_t        : FSM states (IDLE, SETTLE, GATE)
//   SETTLE_CYC_*   : settle length for the filtered / unfiltered input path
//   SETTLE_CYC     : settle length of this build
//   gate_cycles()  : gate window length in clk cycles
// Build option: FREQ_METER_GLITCH_FILTER_EN selects the filtered input path.
package freq_meter_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, GATE} state_t;

  localparam int SETTLE_CYC_NOFILT = 3;
  localparam int SETTLE_CYC_FILT   = 5;

`ifdef FREQ_METER_GLITCH_FILTER_EN
  localparam int SETTLE_CYC = SETTLE_CYC_FILT;
`else
  localparam int SETTLE_CYC = SETTLE_CYC_NOFILT;
`endif

  function automatic int gate_cycles(input longint clk_hz, input longint gate_ms);
    return int'(clk_hz / 64'd1000 * gate_ms);
  endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// edge_sync: brings an asynchronous signal into the clock domain and emits a
// one-cycle pulse per rising edge.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_sig          : asynchronous input
//   o_edge         : 1-cycle rising-edge pulse
// Build option: FREQ_METER_GLITCH_FILTER_EN adds a 3-sample agreement filter
// (pulses shorter than 3 clocks are rejected, edge latency 5 clocks instead of 3).
module edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_edge
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_sig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

`ifdef FREQ_METER_GLITCH_FILTER_EN
  logic r_filt, r_filt_d;

  // s1/s2/s3 are three consecutive samples; the level only moves when all agree.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
    end else begin
      if (r_s1 == r_s2 && r_s2 == r_s3) r_filt <= r_s3;
      r_filt_d <= r_filt;
    end
  end

  assign o_edge = r_filt & ~r_filt_d;
`else
  assign o_edge = r_s2 & ~r_s3;
`endif

endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter. Counts rising edges of sig_in over a
// window of GATE_CYCLES clk_50mhz cycles and presents each result on a
// valid/ready handshake.
//   clk_50mhz, reset_n : clock, async active-low reset
//   enable             : 1 = measure continuously, 0 = idle / abort window
//   sig_in             : asynchronous signal under measurement
//   freq_ready         : consumer accepts result
//   freq_valid         : result available
//   freq_count         : edges in last completed window (saturating)
//   freq_sat           : edge count saturated in that window
//   overrun            : sticky, unconsumed result was overwritten
// Build option: FREQ_METER_GLITCH_FILTER_EN (glitch filter, 5-cycle settle).
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int GATE_MS     = 1000,
  parameter int COUNT_W     = 32
) (
  input  logic               clk_50mhz,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               sig_in,
  input  logic               freq_ready,
  output logic               freq_valid,
  output logic [COUNT_W-1:0] freq_count,
  output logic               freq_sat,
  output logic               overrun
);

  localparam int GATE_CYCLES = gate_cycles(CLK_FREQ_HZ, GATE_MS);
  localparam int GW          = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST   = GW'(GATE_CYCLES - 1);
  localparam logic [2:0]    SETTLE_LAST = 3'(SETTLE_CYC - 1);

  generate
    if (GATE_CYCLES == 0) begin : g_bad_gate
      $error("freq_meter: GATE_CYCLES evaluates to 0");
    end
  endgenerate

  state_t             r_state;
  logic [2:0]         r_settle;
  logic [GW-1:0]      r_gate;
  logic [COUNT_W-1:0] r_edge_cnt;
  logic               r_sat;
  logic               r_valid;
  logic [COUNT_W-1:0] r_count;
  logic               r_fsat;
  logic               r_ovr;

  logic               w_edge;
  logic               w_at_max;
  logic               w_sat_hit;
  logic [COUNT_W-1:0] w_edge_nxt;

  edge_sync u_edge_sync (
    .i_clk   (clk_50mhz),
    .i_rst_n (reset_n),
    .i_sig   (sig_in),
    .o_edge  (w_edge)
  );

  // Edge count including this cycle's edge; holds at all-ones on overflow.
  assign w_at_max   = &r_edge_cnt;
  assign w_sat_hit  = w_edge & w_at_max;
  assign w_edge_nxt = r_edge_cnt + COUNT_W'(w_edge & ~w_at_max);

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_settle   <= '0;
      r_gate     <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_fsat     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      // A capture below overrides this drop (same-cycle handshake + new data).
      if (r_valid && freq_ready) r_valid <= 1'b0;

      if (!enable) begin
        // Abort: discard partial window, keep last result visible.
        r_state    <= IDLE;
        r_settle   <= '0;
        r_gate     <= '0;
        r_edge_cnt <= '0;
        r_sat      <= 1'b0;
        r_ovr      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state  <= SETTLE;
            r_settle <= '0;
          end
          SETTLE: begin
            // Edges from before enable may still sit in the sync chain.
            if (r_settle == SETTLE_LAST) begin
              r_state    <= GATE;
              r_gate     <= '0;
              r_edge_cnt <= '0;
              r_sat      <= 1'b0;
            end else begin
              r_settle <= r_settle + 3'd1;
            end
          end
          GATE: begin
            if (r_gate == GATE_LAST) begin
              // Terminal cycle: this cycle's edge belongs to the closing window.
              r_count    <= w_edge_nxt;
              r_fsat     <= r_sat | w_sat_hit;
              r_valid    <= 1'b1;
              if (r_valid && !freq_ready) r_ovr <= 1'b1;
              r_gate     <= '0;
              r_edge_cnt <= '0;
              r_sat      <= 1'b0;
            end else begin
              r_gate     <= r_gate + GW'(1);
              r_edge_cnt <= w_edge_nxt;
              if (w_sat_hit) r_sat <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign freq_valid = r_valid;
  assign freq_count = r_count;
  assign freq_sat   = r_fsat;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter with a 1000-cycle gate (CLK_FREQ_HZ=1e6, GATE_MS=1).
// A 32-bit and a 4-bit instance share all inputs.
module tb_freq_meter;

`ifdef FREQ_METER_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int SETTLE = FILT ? 5 : 3;
  localparam int LAT    = FILT ? 4 : 2;   // posedges from the one after sig rise to edge count
  localparam int GATE   = 1000;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       sig_in;
  logic       freq_ready;
  logic       freq_valid, freq_sat, overrun;
  logic [31:0] freq_count;
  logic       freq_valid4, freq_sat4, overrun4;
  logic [3:0] freq_count4;

  freq_meter #(.CLK_FREQ_HZ(1_000_000), .GATE_MS(1), .COUNT_W(32)) u_dut (
    .clk_50mhz(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .freq_ready(freq_ready), .freq_valid(freq_valid), .freq_count(freq_count),
    .freq_sat(freq_sat), .overrun(overrun)
  );

  freq_meter #(.CLK_FREQ_HZ(1_000_000), .GATE_MS(1), .COUNT_W(4)) u_dut4 (
    .clk_50mhz(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .freq_ready(freq_ready), .freq_valid(freq_valid4), .freq_count(freq_count4),
    .freq_sat(freq_sat4), .overrun(overrun4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // periodic stimulus, advanced once per step
  bit gen_en  = 1'b0;
  int gen_per = 10;
  int gen_hi  = 5;
  int gcnt    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // one clock; on return we sit at the negedge, inputs updated
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (gen_en) begin
      gcnt   = (gcnt + 1) % gen_per;
      sig_in = (gcnt < gen_hi);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input string nm, input int max, output int n);
    n = 0;
    while (!freq_valid && n < max) begin
      step();
      n++;
    end
    if (!freq_valid) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic set_gen(input int per, input int hi);
    gen_per = per;
    gen_hi  = hi;
    gcnt    = 0;
    gen_en  = 1'b1;
  endtask

  typedef struct {
    bit gen;
    int per;
    int hi;
    bit lvl;
    int exp_cnt;
    bit exp_sat;
    int exp_cnt4;
    bit exp_sat4;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    int seen;
    int c;

    vecs[0] = '{1'b1, 10,  5,   1'b0, 100, 1'b0, 15, 1'b1};
    vecs[1] = '{1'b0, 1,   0,   1'b1, 0,   1'b0, 0,  1'b0};
    vecs[2] = '{1'b1, 4,   2,   1'b0, FILT ? 0 : 250, 1'b0, FILT ? 0 : 15, !FILT};
    vecs[3] = '{1'b1, 8,   4,   1'b0, 125, 1'b0, 15, 1'b1};
    vecs[4] = '{1'b1, 100, 50,  1'b0, 10,  1'b0, 10, 1'b0};
    vecs[5] = '{1'b1, 2,   1,   1'b0, FILT ? 0 : 500, 1'b0, FILT ? 0 : 15, !FILT};
    vecs[6] = '{1'b0, 1,   0,   1'b0, 0,   1'b0, 0,  1'b0};
    vecs[7] = '{1'b1, 250, 3,   1'b0, 4,   1'b0, 4,  1'b0};

    reset_n    = 1'b0;
    enable     = 1'b0;
    sig_in     = 1'b0;
    freq_ready = 1'b1;
    steps(5);
    chk("rst_valid", freq_valid, 0);
    chk("rst_count", freq_count, 0);
    chk("rst_sat",   freq_sat,   0);
    chk("rst_ovr",   overrun,    0);
    chk("rst_count4", freq_count4, 0);

    // first window latency and value
    set_gen(10, 5);
    reset_n = 1'b1;
    step();
    enable = 1'b1;
    wait_valid("first", 2000, n);
    chk("first_latency", n, 1 + SETTLE + GATE);
    chk("first_count",  freq_count, 100);
    chk("first_sat",    freq_sat,   0);
    chk("first_count4", freq_count4, 15);
    chk("first_sat4",   freq_sat4,  1);
    step();
    chk("first_valid_drop", freq_valid, 0);

    // steady-state windows for several input patterns
    foreach (vecs[i]) begin
      if (vecs[i].gen) set_gen(vecs[i].per, vecs[i].hi);
      else begin
        gen_en = 1'b0;
        sig_in = vecs[i].lvl;
      end
      wait_valid($sformatf("v%0d_a", i), 1100, n);
      step();
      wait_valid($sformatf("v%0d_b", i), 1100, n);
      chk($sformatf("v%0d_count", i),  freq_count,  vecs[i].exp_cnt);
      chk($sformatf("v%0d_sat", i),    freq_sat,    vecs[i].exp_sat);
      chk($sformatf("v%0d_count4", i), freq_count4, vecs[i].exp_cnt4);
      chk($sformatf("v%0d_sat4", i),   freq_sat4,   vecs[i].exp_sat4);
      step();
      chk($sformatf("v%0d_valid_drop", i), freq_valid, 0);
      steps(400);
      chk($sformatf("v%0d_hold", i), freq_count, vecs[i].exp_cnt);
    end

    // overrun: two windows without ready
    set_gen(10, 5);
    wait_valid("ovr_a", 1100, n);
    step();
    freq_ready = 1'b0;
    wait_valid("ovr_w1", 1100, n);
    chk("ovr_w1_count", freq_count, 100);
    chk("ovr_w1_flag",  overrun, 0);
    n = 0;
    while (!overrun && n < 1100) begin
      step();
      n++;
    end
    chk("ovr_delay",    n, GATE);
    chk("ovr_w2_valid", freq_valid, 1);
    chk("ovr_w2_count", freq_count, 100);
    freq_ready = 1'b1;
    step();
    chk("ovr_valid_drop", freq_valid, 0);
    chk("ovr_sticky",     overrun, 1);
    enable = 1'b0;
    step();
    chk("ovr_clear",      overrun, 0);
    chk("ovr_count_kept", freq_count, 100);

    // abort mid-window
    enable = 1'b1;
    wait_valid("abort_pre", 1100, n);
    chk("reenable_latency", n, 1 + SETTLE + GATE);
    steps(500);
    enable = 1'b0;
    seen = 0;
    for (int k = 0; k < 1200; k++) begin
      step();
      if (freq_valid) seen++;
    end
    chk("abort_no_valid",  seen, 0);
    chk("abort_count_kept", freq_count, 100);
    enable = 1'b1;
    wait_valid("abort_post", 1200, n);
    chk("abort_full_window", n, 1 + SETTLE + GATE);
    chk("abort_post_count", freq_count, 100);
    step();

    // edge landing on the terminal cycle
    gen_en = 1'b0;
    sig_in = 1'b0;
    wait_valid("term_a", 1100, n);
    step();
    wait_valid("term_p0", 1100, n);
    for (c = 1; c <= 2001; c++) begin
      step();
      sig_in = (c >= 100 && c <= 104) ||
               (c >= GATE - 1 - LAT && c <= GATE + 3 - LAT) ||
               (c >= 1050 && c <= 1054);
      if (c == GATE) begin
        chk("term_valid",  freq_valid, 1);
        chk("term_count",  freq_count, 2);
        chk("term_count4", freq_count4, 2);
      end
      if (c == GATE + 1) chk("term_valid_drop", freq_valid, 0);
      if (c == 2 * GATE) begin
        chk("term_next_valid", freq_valid, 1);
        chk("term_next_count", freq_count, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Gated frequency counter: the measuring counterpart of the 1 Hz divider. A divider turns clk_50mhz into a slow clock; this block takes a slow, asynchronous external signal and reports its rising-edge count per gate window, timed by clk_50mhz.
- Sits between board input pins (test clocks, sensor pulses) and the status/display logic.
- Result is presented on a valid/ready handshake.

Parameters:
- CLK_FREQ_HZ, 50_000_000, frequency of clk_50mhz in Hz.
- GATE_MS, 1000, gate window length in ms; GATE_CYCLES = CLK_FREQ_HZ/1000*GATE_MS (elaboration error if 0).
- COUNT_W, 32, width of edge counter and result.

Ports:
- clk_50mhz, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- enable, in, 1: level; 1 = measure continuously, 0 = idle/abort.
- sig_in, in, 1: asynchronous signal under measurement.
- freq_ready, in, 1: consumer accepts result.
- freq_valid, out, 1: result available.
- freq_count, out, COUNT_W: rising edges in last completed window (Hz when GATE_MS=1000).
- freq_sat, out, 1: edge count saturated in that window.
- overrun, out, 1: sticky; an unconsumed result was overwritten.

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; all counters 0.
  - freq_valid=0, freq_count=0, freq_sat=0, overrun=0.
  - Sync flops = 0.
- Input path:
  - 2-flop synchronizer, then a previous-sample flop.
  - edge = s2 & ~s3; an edge is visible 3 clocks after the sig_in rise.
- FSM:
  - IDLE: while enable=0, counters held at 0. On enable=1, go to SETTLE.
  - SETTLE: 3 cycles (5 with filter); edges ignored; flushes stale sync state. Then go to GATE with gate_cnt=0 and edge_cnt=0.
  - GATE: gate_cnt increments each cycle; edge_cnt increments on edge, saturating at all-ones (sets the sat flag).
  - GATE terminal cycle (gate_cnt==GATE_CYCLES-1):
    - freq_count <= edge_cnt + edge, saturating.
    - freq_sat <= window sat flag.
    - freq_valid <= 1.
    - gate_cnt <= 0, edge_cnt <= 0, sat flag cleared.
    - Stay in GATE. No dead cycle; no edge lost or double-counted across windows.
  - enable=0 in any state: next state IDLE; partial window discarded. freq_count, freq_sat and freq_valid keep their values. overrun cleared.
- Handshake:
  - freq_valid & freq_ready: freq_valid falls next cycle.
  - Capture in the same cycle as a handshake: freq_valid stays 1, new data loaded, no overrun.
  - Capture while freq_valid=1 and freq_ready=0: data overwritten, overrun <= 1.
  - overrun clears only on reset or enable=0.
- freq_count/freq_sat change only on a capture cycle; stable while freq_valid=1 and no capture.
- Reset mid-window: immediate return to IDLE with all outputs at reset values.
- sig_in faster than clk_50mhz/2: undercount; not flagged.

Optional Feature:
- Macro FREQ_METER_GLITCH_FILTER_EN.
- Defined: a filtered level follows s2 only after 3 consecutive equal samples; edge is taken from the filtered level; input latency 5 clocks; SETTLE is 5 cycles; pulses shorter than 3 clocks are rejected.
- Undefined: no filter, latency 3, SETTLE 3.

Decomposition:
- Package freq_meter_pkg:
  - state enum (IDLE, SETTLE, GATE).
  - function for GATE_CYCLES.
  - SETTLE length constants for the filter and no-filter builds.
- Sub-module edge_sync: synchronizer, optional filter and rising-edge pulse; output is the 1-cycle edge.
- FSM, counters and handshake stay in freq_meter.

Test Plan (CLK_FREQ_HZ=1_000_000, GATE_MS=1, GATE_CYCLES=1000; freq_ready=1 unless stated):
- Reset low 5 cycles, enable=1, sig_in period 10 clk: after SETTLE plus 1000 cycles, freq_valid=1 for 1 cycle, freq_count=100. Every later window also gives 100.
- sig_in held constant 1: freq_count=0 each window, freq_sat=0.
- freq_ready=0 across two windows: second capture gives overrun=1 with freq_count equal to the second window's value. Then freq_ready=1: freq_valid drops next cycle, overrun stays 1. Then enable=0: overrun=0.
- sig_in edge placed exactly on the terminal cycle: counted in the closing window; the next window starts at 0. Windows total 100 with no loss or duplicate.
- enable=0 at gate_cnt=500: FSM IDLE next cycle, no freq_valid pulse, freq_count unchanged. Re-enable gives a full 1000-cycle window.
- COUNT_W=4, sig_in period 4 clk: freq_count=15, freq_sat=1.
- With FREQ_METER_GLITCH_FILTER_EN: 2-clk-wide pulses give 0; 4-clk-wide pulses are counted.
